// File: rtl/sar_pkg.sv
// sar_pkg: shared FSM state encoding and default sizing for the SAR ADC controller
package sar_pkg;
  localparam int SAR_N          = 6;
  localparam int SAR_SAMPLE_CYC = 2;
  localparam int SAR_SETTLE_CYC = 1;
  typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, COMPARE, DECIDE, DONE} sar_state_e;
endpackage

// File: rtl/sar_adc_ctrl_if.sv
// sar_adc_ctrl_if: analog front-end strobes plus result valid/ready handshake
// master: controller side (drives sample/comp_en/dac/result/busy/overrun)
// slave: environment side (drives start, comp_out, result_ready)
interface sar_adc_ctrl_if import sar_pkg::*; #(parameter int N = SAR_N);
  logic         start;
  logic         comp_out;
  logic         sample;
  logic         comp_en;
  logic [N-1:0] dac_code;
  logic [N-1:0] dac_codeb;
  logic [N-1:0] bit_strobe;
  logic         busy;
  logic [N-1:0] result;
  logic         result_valid;
  logic         result_ready;
  logic         overrun;
  modport master (input start, comp_out, result_ready,
                  output sample, comp_en, dac_code, dac_codeb, bit_strobe, busy, result, result_valid, overrun);
  modport slave  (output start, comp_out, result_ready,
                  input sample, comp_en, dac_code, dac_codeb, bit_strobe, busy, result, result_valid, overrun);
endinterface

// File: rtl/sar_cycle_timer.sv
// sar_cycle_timer: loadable down-counter, done while the count is zero
// ports: clk, rst, load (load_val into counter), load_val, done
module sar_cycle_timer #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : cnt - W'(cnt != '0);
  assign done = cnt == '0;
endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: start-triggered successive-approximation controller for an N-bit SAR ADC
// ports: clk, rst (sync, active-high), bus (sar_adc_ctrl_if.master: start, comp_out,
//   result_ready in; sample, comp_en, dac_code, dac_codeb, bit_strobe, busy, result,
//   result_valid, overrun out). All outputs are registered from the current state,
//   so they trail the state register by one cycle.
// AUTO_RESTART_EN: when defined, an accepted result restarts sampling without start.
module sar_adc_ctrl import sar_pkg::*; #(
  parameter int N          = SAR_N,
  parameter int SAMPLE_CYC = SAR_SAMPLE_CYC,
  parameter int SETTLE_CYC = SAR_SETTLE_CYC
) (
  input logic             clk,
  input logic             rst,
  sar_adc_ctrl_if.master  bus
);
`ifdef AUTO_RESTART_EN
  localparam bit auto_rs = 1'b1;
`else
  localparam bit auto_rs = 1'b0;
`endif
  localparam int TW = 16;
  localparam int IW = $clog2(N);
  sar_state_e   state, nxt;
  logic [IW-1:0] i;
  logic [N-1:0] code, bit_oh;
  logic         ld, t_done, ack, trial, fin;
  logic [TW-1:0] ld_val;
  sar_cycle_timer #(.W(TW)) u_timer (.clk, .rst, .load(ld), .load_val(ld_val), .done(t_done));
  assign ack    = state == DONE && bus.result_valid && bus.result_ready;
  assign trial  = state == SETTLE || state == COMPARE || state == DECIDE;
  assign fin    = state == DONE && !ack;
  assign bit_oh = N'(1) << i;
  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = TW'(SETTLE_CYC - 1);
    case (state)
      IDLE:    if (bus.start) begin
                 nxt    = SAMPLE;
                 ld     = 1'b1;
                 ld_val = TW'(SAMPLE_CYC - 1);
               end
      SAMPLE:  if (t_done) begin
                 nxt = SETTLE;
                 ld  = 1'b1;
               end
      SETTLE:  nxt = t_done ? COMPARE : SETTLE;
      COMPARE: nxt = DECIDE;
      DECIDE:  begin
                 nxt = i == '0 ? DONE : SETTLE;
                 ld  = i != '0;
               end
      DONE:    if (ack) begin
                 nxt    = auto_rs ? SAMPLE : IDLE;
                 ld     = auto_rs;
                 ld_val = TW'(SAMPLE_CYC - 1);
               end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      code             <= '0;
      i                <= '0;
      bus.sample       <= 1'b0;
      bus.comp_en      <= 1'b0;
      bus.dac_code     <= '0;
      bus.dac_codeb    <= '1;
      bus.bit_strobe   <= '0;
      bus.busy         <= 1'b0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      state <= nxt;
      if (state == SAMPLE && t_done) begin
        code <= '0;
        i    <= IW'(N - 1);
      end
      if (state == DECIDE) begin
        code[i] <= bus.comp_out;
        if (i != '0) i <= i - IW'(1);
      end
      bus.sample       <= state == SAMPLE;
      bus.comp_en      <= state == COMPARE;
      bus.bit_strobe   <= trial ? bit_oh : '0;
      bus.dac_code     <= trial ? (code | bit_oh) : fin ? code : '0;
      bus.dac_codeb    <= ~(trial ? (code | bit_oh) : fin ? code : '0);
      bus.result       <= fin ? code : '0;
      bus.result_valid <= fin;
      bus.busy         <= state != IDLE && !(ack && !auto_rs);
      bus.overrun      <= !auto_rs && bus.start && state != IDLE;
    end
  end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed tests of sar_adc_ctrl (defaults and SAMPLE_CYC=4/SETTLE_CYC=3)
module tb_sar_adc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] vin = 6'd0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sar_adc_ctrl_if #(.N(6)) b1 ();
  sar_adc_ctrl_if #(.N(6)) b2 ();
  assign b1.comp_out = vin >= b1.dac_code;
  assign b2.comp_out = 6'd37 >= b2.dac_code;
  sar_adc_ctrl dut (.clk(clk), .rst(rst), .bus(b1));
  sar_adc_ctrl #(.N(6), .SAMPLE_CYC(4), .SETTLE_CYC(3)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  task automatic do_conv(input bit u, input logic [5:0] v, output int lat, output logic [5:0] res,
                         output int ncomp, output int nsamp, output logic [35:0] trials,
                         output logic [35:0] strobes);
    lat = -1; res = '0; ncomp = 0; nsamp = 0; trials = '0; strobes = '0;
    vin = v;
    if (u) b2.start = 1'b1; else b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0; b2.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (u ? b2.comp_en : b1.comp_en) begin
        ncomp++;
        trials  = {trials[29:0], u ? b2.dac_code : b1.dac_code};
        strobes = {strobes[29:0], u ? b2.bit_strobe : b1.bit_strobe};
      end
      if (u ? b2.sample : b1.sample) nsamp++;
      if (u ? b2.result_valid : b1.result_valid) begin
        lat = k;
        res = u ? b2.result : b1.result;
        break;
      end
    end
  endtask
  task automatic accept(input bit u);
    if (u) b2.result_ready = 1'b1; else b1.result_ready = 1'b1;
    @(posedge clk); #1;
    b1.result_ready = 1'b0; b2.result_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b1.sample, b1.comp_en, b1.busy, b1.result_valid, b1.overrun} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {b1.sample, b1.comp_en, b1.busy, b1.result_valid, b1.overrun});
    end
    checks++;
    if ({b1.dac_code, b1.bit_strobe, b1.result} !== 18'h0) begin
      errors++; $display("FAIL reset_codes: got %h want 0", {b1.dac_code, b1.bit_strobe, b1.result});
    end
    checks++;
    if (b1.dac_codeb !== 6'h3f) begin
      errors++; $display("FAIL reset_codeb: got %h want 3f", b1.dac_codeb);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
`ifdef AUTO_RESTART_EN
  task automatic test_auto;
    int r[3];
    int n = 0;
    int ov = 0;
    int bad = 0;
    logic pv = 1'b0;
    b1.result_ready = 1'b1;
    vin = 6'd37;
    b1.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 80 && n < 3; k++) begin
      @(posedge clk); #1;
      if (b1.overrun) ov++;
      if (b1.result_valid && !pv) begin
        r[n] = k;
        n++;
        if (b1.result !== 6'd37) bad++;
      end
      pv = b1.result_valid;
    end
    b1.start = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL auto_count: got %0d results want 3", n);
    end else begin
      checks++;
      if (r[0] !== 21) begin errors++; $display("FAIL auto_first: got %0d want 21", r[0]); end
      checks++;
      if (r[1] - r[0] !== 22 || r[2] - r[1] !== 22) begin
        errors++; $display("FAIL auto_period: got %0d,%0d want 22,22", r[1] - r[0], r[2] - r[1]);
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL auto_result: got %0d wrong results want 0", bad); end
    checks++;
    if (ov !== 0) begin errors++; $display("FAIL auto_overrun: got %0d pulses want 0", ov); end
  endtask
`else
  task automatic test_conv37;
    int lat, nc, ns;
    logic [5:0] res;
    logic [35:0] tr, st;
    do_conv(0, 6'd37, lat, res, nc, ns, tr, st);
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL conv37_latency: got %0d want 21", lat); end
    checks++;
    if (res !== 6'd37) begin errors++; $display("FAIL conv37_result: got %0d want 37", res); end
    checks++;
    if (tr !== {6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37}) begin
      errors++; $display("FAIL conv37_trials: got %h want %h", tr, {6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37});
    end
    checks++;
    if (nc !== 6 || ns !== 2) begin
      errors++; $display("FAIL conv37_pulses: got comp_en=%0d sample=%0d want 6 2", nc, ns);
    end
    checks++;
    if (b1.dac_codeb !== ~6'd37) begin errors++; $display("FAIL conv37_codeb: got %h want %h", b1.dac_codeb, ~6'd37); end
    accept(0);
    checks++;
    if (b1.result_valid !== 1'b0 || b1.busy !== 1'b0) begin
      errors++; $display("FAIL conv37_accept: got valid=%b busy=%b want 0 0", b1.result_valid, b1.busy);
    end
  endtask
  task automatic test_extremes;
    int lat, nc, ns;
    logic [5:0] res;
    logic [35:0] tr, st;
    logic [5:0] vs[2] = '{6'd0, 6'd63};
    logic [35:0] et[2] = '{{6'd32, 6'd16, 6'd8, 6'd4, 6'd2, 6'd1}, {6'd32, 6'd48, 6'd56, 6'd60, 6'd62, 6'd63}};
    for (int t = 0; t < 2; t++) begin
      do_conv(0, vs[t], lat, res, nc, ns, tr, st);
      checks++;
      if (res !== vs[t]) begin errors++; $display("FAIL extreme_result: got %0d want %0d", res, vs[t]); end
      checks++;
      if (tr !== et[t]) begin errors++; $display("FAIL extreme_trials: got %h want %h", tr, et[t]); end
      checks++;
      if (nc !== 6 || ns !== 2) begin
        errors++; $display("FAIL extreme_pulses: got comp_en=%0d sample=%0d want 6 2", nc, ns);
      end
      accept(0);
    end
  endtask
  task automatic test_hold;
    int lat, nc, ns, ov, bad, nsamp;
    logic [5:0] res;
    logic [35:0] tr, st;
    do_conv(0, 6'd37, lat, res, nc, ns, tr, st);
    ov = 0; bad = 0; nsamp = 0;
    for (int k = 1; k <= 10; k++) begin
      b1.start = (k == 3 || k == 6);
      @(posedge clk); #1;
      b1.start = 1'b0;
      if (b1.overrun) ov++;
      if (b1.sample) nsamp++;
      if (b1.result !== 6'd37 || b1.busy !== 1'b1 || b1.result_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
    checks++;
    if (ov !== 2) begin errors++; $display("FAIL hold_overrun: got %0d pulses want 2", ov); end
    checks++;
    if (nsamp !== 0) begin errors++; $display("FAIL hold_nosample: got %0d sample cycles want 0", nsamp); end
    b1.start = 1'b1; b1.result_ready = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0; b1.result_ready = 1'b0;
    checks++;
    if (b1.result_valid !== 1'b0 || b1.overrun !== 1'b1) begin
      errors++; $display("FAIL hold_accept_start: got valid=%b overrun=%b want 0 1", b1.result_valid, b1.overrun);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b1.busy !== 1'b0 || b1.sample !== 1'b0) begin
      errors++; $display("FAIL hold_dropped: got busy=%b sample=%b want 0 0", b1.busy, b1.sample);
    end
  endtask
  task automatic test_reset_mid;
    int lat, nc, ns;
    logic [5:0] res;
    logic [35:0] tr, st;
    vin = 6'd37;
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (b1.bit_strobe !== 6'b010000) begin errors++; $display("FAIL mid_progress: got %b want 010000", b1.bit_strobe); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({b1.sample, b1.comp_en, b1.busy, b1.result_valid, b1.overrun, b1.dac_code, b1.bit_strobe, b1.result, b1.dac_codeb}
        !== {5'b0, 18'h0, 6'h3f}) begin
      errors++; $display("FAIL mid_reset: got %h want %h", {b1.sample, b1.comp_en, b1.busy, b1.result_valid, b1.overrun,
                         b1.dac_code, b1.bit_strobe, b1.result, b1.dac_codeb}, {5'b0, 18'h0, 6'h3f});
    end
    do_conv(0, 6'd37, lat, res, nc, ns, tr, st);
    checks++;
    if (res !== 6'd37 || lat !== 21) begin errors++; $display("FAIL mid_reconv: got %0d in %0d want 37 in 21", res, lat); end
    accept(0);
  endtask
  task automatic test_timing;
    int lat, nc, ns;
    logic [5:0] res;
    logic [35:0] tr, st;
    do_conv(1, 6'd37, lat, res, nc, ns, tr, st);
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL timing_latency: got %0d want 35", lat); end
    checks++;
    if (res !== 6'd37) begin errors++; $display("FAIL timing_result: got %0d want 37", res); end
    checks++;
    if (st !== {6'd32, 6'd16, 6'd8, 6'd4, 6'd2, 6'd1} || ns !== 4) begin
      errors++; $display("FAIL timing_strobe: got %h sample=%0d want %h 4", st, ns, {6'd32, 6'd16, 6'd8, 6'd4, 6'd2, 6'd1});
    end
    accept(1);
  endtask
  task automatic test_back_to_back;
    int lat, nc, ns;
    logic [5:0] res;
    logic [35:0] tr, st;
    do_conv(0, 6'd5, lat, res, nc, ns, tr, st);
    checks++;
    if (res !== 6'd5) begin errors++; $display("FAIL b2b_first: got %0d want 5", res); end
    accept(0);
    do_conv(0, 6'd58, lat, res, nc, ns, tr, st);
    checks++;
    if (res !== 6'd58) begin errors++; $display("FAIL b2b_second: got %0d want 58", res); end
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL b2b_latency: got %0d want 21", lat); end
    accept(0);
  endtask
`endif
  initial begin
    b1.start = 1'b0; b1.result_ready = 1'b0;
    b2.start = 1'b0; b2.result_ready = 1'b0;
    test_reset;
`ifdef AUTO_RESTART_EN
    test_auto;
`else
    test_conv37;
    test_extremes;
    test_hold;
    test_reset_mid;
    test_timing;
    test_back_to_back;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
